div_accel: RTL and testbench

Memory-mapped iterative 32-bit integer divider for the single-cycle MIPS SoC. It sits behind the SoC address decoder as a bus responder next to the existing accelerators. The processor writes the operands and a start command over the store path and reads the quotient and remainder back over the load path. A `done` level is exported to the processor's status inputs, in the same way as `faccel_done` and `FPM_done`.

---
 rtl/div_accel.sv | 151 +++++++++++++++
 tb/tb_div_accel.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_accel.sv
// Memory-mapped 32-bit restoring divider: operands/start via stores, results via loads; optional signed mode under DIV_SIGNED_EN.
// Latency: done 32 cycles after the start edge (1 cycle for divide-by-zero); data_out is combinational.
// Backpressure: none; a start written while running is dropped and the operation in flight is unaffected.
module div_accel #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sel,
    input  logic             WE,
    input  logic [2:0]       A,
    input  logic [WIDTH-1:0] write_data,
    output logic [WIDTH-1:0] data_out,
    output logic             done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] dividend_r, divisor_r, quotient_r, remainder_r;
    logic             err;
    logic [WIDTH-1:0] w_q, w_r, w_d;
    logic [4:0]       cnt;

    logic wr_ctrl, start, ack, busy;

    assign wr_ctrl = sel & WE & (A == 3'd2);
    assign start   = wr_ctrl & write_data[0] & (state != S_RUN);
    assign ack     = wr_ctrl & ~write_data[0] & (state == S_DONE);
    // A zero divisor passes through RUN for one edge only and never reports busy.
    assign busy    = (state == S_RUN) & (w_d != '0);
    assign done    = (state == S_DONE);

    logic [WIDTH:0]   partial, trial;
    logic [WIDTH-1:0] nq, nr;

    always_comb begin
        partial = {w_r, w_q[WIDTH-1]};
        trial   = partial - {1'b0, w_d};
        if (trial[WIDTH]) begin
            nr = partial[WIDTH-1:0];
            nq = {w_q[WIDTH-2:0], 1'b0};
        end else begin
            nr = trial[WIDTH-1:0];
            nq = {w_q[WIDTH-2:0], 1'b1};
        end
    end

    logic [WIDTH-1:0] a_abs, b_abs, q_fin, r_fin, z_rem;

`ifdef DIV_SIGNED_EN
    logic a_neg, b_neg, neg_q, neg_r;

    assign a_neg = write_data[1] & dividend_r[WIDTH-1];
    assign b_neg = write_data[1] & divisor_r[WIDTH-1];
    assign a_abs = a_neg ? -dividend_r : dividend_r;
    assign b_abs = b_neg ? -divisor_r  : divisor_r;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            neg_q <= 1'b0;
            neg_r <= 1'b0;
        end else if (start) begin
            neg_q <= a_neg ^ b_neg;
            neg_r <= a_neg;
        end
    end

    assign q_fin = neg_q ? -nq : nq;
    assign r_fin = neg_r ? -nr : nr;
    // w_q still holds |dividend| on the divide-by-zero edge; restore the original value.
    assign z_rem = neg_r ? -w_q : w_q;
`else
    assign a_abs = dividend_r;
    assign b_abs = divisor_r;
    assign q_fin = nq;
    assign r_fin = nr;
    assign z_rem = w_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            dividend_r  <= '0;
            divisor_r   <= '0;
            quotient_r  <= '0;
            remainder_r <= '0;
            err         <= 1'b0;
            w_q         <= '0;
            w_r         <= '0;
            w_d         <= '0;
            cnt         <= '0;
        end else begin
            if (sel & WE) begin
                case (A)
                    3'd0:    dividend_r <= write_data;
                    3'd1:    divisor_r  <= write_data;
                    default: ;
                endcase
            end
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state <= S_RUN;
                        w_q   <= a_abs;
                        w_d   <= b_abs;
                        w_r   <= '0;
                        cnt   <= '0;
                        err   <= 1'b0;
                    end else if (ack) begin
                        state <= S_IDLE;
                        err   <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_d == '0) begin
                        state       <= S_DONE;
                        quotient_r  <= '1;
                        remainder_r <= z_rem;
                        err         <= 1'b1;
                    end else begin
                        w_q <= nq;
                        w_r <= nr;
                        cnt <= cnt + 5'd1;
                        if (cnt == 5'd31) begin
                            state       <= S_DONE;
                            quotient_r  <= q_fin;
                            remainder_r <= r_fin;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        data_out = '0;
        case (A)
            3'd0:    data_out = dividend_r;
            3'd1:    data_out = divisor_r;
            3'd2:    data_out = {{(WIDTH-3){1'b0}}, err, busy, done};
            3'd3:    data_out = quotient_r;
            3'd4:    data_out = remainder_r;
            default: data_out = '0;
        endcase
    end

endmodule

// File: tb/tb_div_accel.sv
// Randomized + directed bench for div_accel against an arithmetic reference model.
module tb_div_accel;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sel = 1'b0;
    logic        WE = 1'b0;
    logic [2:0]  A = 3'd0;
    logic [31:0] write_data = 32'd0;
    logic [31:0] data_out;
    logic        done;

    always #5 clk = ~clk;

    div_accel #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .sel        (sel),
        .WE         (WE),
        .A          (A),
        .write_data (write_data),
        .data_out   (data_out),
        .done       (done)
    );

    int tests = 0;
    int fails = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: register file plus a countdown to the result, results from / and %.
    logic [31:0] m_a = 0, m_b = 0, m_q = 0, m_r = 0, p_q = 0, p_r = 0;
    bit          m_done = 0, m_err = 0, m_run = 0, m_div0 = 0, p_err = 0;
    bit          pre_run, pre_done;
    int          m_left = 0;

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return m_a;
            3'd1:    return m_b;
            3'd2:    return {29'd0, m_err, (m_run && !m_div0), m_done};
            3'd3:    return m_q;
            3'd4:    return m_r;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_start(input bit sgn);
        m_done = 0;
        m_err  = 0;
        m_run  = 1;
        if (m_b == 0) begin
            m_div0 = 1;
            m_left = 1;
            p_q    = 32'hFFFF_FFFF;
            p_r    = m_a;
            p_err  = 1;
        end else begin
            m_div0 = 0;
            m_left = 32;
            p_err  = 0;
`ifdef DIV_SIGNED_EN
            if (sgn) begin
                if (m_a == 32'h8000_0000 && m_b == 32'hFFFF_FFFF) begin
                    p_q = 32'h8000_0000;
                    p_r = 32'd0;
                end else begin
                    p_q = $signed(m_a) / $signed(m_b);
                    p_r = $signed(m_a) % $signed(m_b);
                end
            end else
`endif
            begin
                p_q = m_a / m_b;
                p_r = m_a % m_b;
            end
        end
    endtask

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_a = 0; m_b = 0; m_q = 0; m_r = 0;
            m_done = 0; m_err = 0; m_run = 0; m_div0 = 0; m_left = 0;
        end else begin
            pre_run  = m_run;
            pre_done = m_done;
            if (sel && WE) begin
                case (A)
                    3'd0: m_a = write_data;
                    3'd1: m_b = write_data;
                    3'd2: begin
                        if (write_data[0] && !pre_run) model_start(write_data[1]);
                        else if (!write_data[0] && pre_done) begin
                            m_done = 0;
                            m_err  = 0;
                        end
                    end
                    default: ;
                endcase
            end
            if (pre_run) begin
                m_left--;
                if (m_left == 0) begin
                    m_run  = 0;
                    m_done = 1;
                    m_q    = p_q;
                    m_r    = p_r;
                    m_err  = p_err;
                end
            end
        end
    end

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            check("data_out", data_out, m_read(A));
            check("done", {31'd0, done}, {31'd0, m_done});
        end
    end

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        sel = 1; WE = 1; A = a; write_data = d;
        @(negedge clk);
        sel = 0; WE = 0; A = 3'($urandom_range(0, 7));
    endtask

    task automatic rd(input logic [2:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        sel = 1; WE = 0; A = a;
        #1;
        check(name, data_out, exp);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (1) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (n >= 100) begin
                tests++;
                fails++;
                $display("FAIL wait_done: done still 0 after %0d cycles, required 1", n);
                break;
            end
            A = 3'($urandom_range(0, 7));
        end
    endtask

    initial begin
        int n;
        logic [31:0] a, b;
        bit sg;

        #2 reset = 0;
        #20;
        @(negedge clk);
        reset = 1;
        chk_en = 1;

        for (int i = 0; i < 8; i++) rd(3'(i), 32'd0, "reset_read");
        check("reset_done", {31'd0, done}, 32'd0);

        // 100 / 7
        wr(0, 100); wr(1, 7); wr(2, 1);
        A = 3'd2; #1;
        check("busy_after_start", data_out, 32'd2);
        wait_done(n);
        check("latency_100_7", n, 32'd32);
        rd(3, 32'd14, "q_100_7");
        rd(4, 32'd2, "r_100_7");
        rd(2, 32'd1, "status_100_7");
        wr(2, 0);
        rd(2, 32'd0, "status_after_ack");
        rd(3, 32'd14, "q_retained");

        // divide by zero
        wr(0, 32'h1234_5678); wr(1, 0); wr(2, 1);
        wait_done(n);
        check("latency_div0", n, 32'd1);
        rd(2, 32'd5, "status_div0");
        rd(3, 32'hFFFF_FFFF, "q_div0");
        rd(4, 32'h1234_5678, "r_div0");

        // start ignored while running
        wr(0, 32'hFFFF_FFFF); wr(1, 32'h10); wr(2, 1);
        repeat (8) @(negedge clk);
        wr(1, 3); wr(2, 1);
        wait_done(n);
        rd(3, 32'h0FFF_FFFF, "q_ignored_start");
        rd(4, 32'h0000_000F, "r_ignored_start");
        rd(1, 32'd3, "divisor_visible");

        // reset mid-run
        wr(0, 1000); wr(1, 7); wr(2, 1);
        repeat (14) @(negedge clk);
        sel = 1; WE = 0; A = 3'd2;
        reset = 0;
        #1;
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_status", data_out, 32'd0);
        @(negedge clk);
        reset = 1;
        rd(3, 32'd0, "rst_q");
        rd(4, 32'd0, "rst_r");
        wr(0, 9); wr(1, 3); wr(2, 1);
        wait_done(n);
        rd(3, 32'd3, "q_9_3");
        rd(4, 32'd0, "r_9_3");

`ifdef DIV_SIGNED_EN
        wr(0, 32'hFFFF_FFF9); wr(1, 2); wr(2, 3);
        wait_done(n);
        rd(3, 32'hFFFF_FFFD, "q_m7_2");
        rd(4, 32'hFFFF_FFFF, "r_m7_2");
        wr(0, 32'h8000_0000); wr(1, 32'hFFFF_FFFF); wr(2, 3);
        wait_done(n);
        rd(3, 32'h8000_0000, "q_min_m1");
        rd(4, 32'd0, "r_min_m1");
        rd(2, 32'd1, "status_min_m1");
        wr(2, 0);
        rd(2, 32'd0, "status_signed_ack");
`endif

        // randomized operations
        for (int i = 0; i < 40; i++) begin
            a = $urandom;
            case ($urandom_range(0, 3))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = $urandom;
                default: b = $urandom >> 16;
            endcase
            sg = 1'($urandom_range(0, 1));
            wr(0, a); wr(1, b); wr(2, {30'd0, sg, 1'b1});
            wait_done(n);
            check("rand_latency", n, (b == 0) ? 32'd1 : 32'd32);
            if ($urandom_range(0, 1) == 1) wr(2, 0);
        end

        // random bus traffic soak
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                sel = 1; WE = 1; A = 3'($urandom_range(0, 7)); write_data = $urandom;
            end else begin
                sel = 0; WE = 0; A = 3'($urandom_range(0, 7));
            end
        end
        @(negedge clk);
        sel = 0; WE = 0;
        repeat (40) @(negedge clk);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
